bcd_clock_alarm_bank: RTL and testbench

//  Parametrised successor to the single-alarm hour counter: BCD HH:MM:SS timekeeper with a
//  1 Hz tick prescaler, 12/24h output mode, and NUM_ALARMS independently programmable alarms.

---
 rtl/bcd_clock_alarm_bank_if.sv | 14 +
 rtl/bcd_clock_alarm_bank.sv | 170 +++++++++++++++++
 tb/tb_bcd_clock_alarm_bank.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_clock_alarm_bank_if.sv
// Alarm programming bus for bcd_clock_alarm_bank.
// Carries the write strobe, channel index and BCD hh_mm alarm time.
interface bcd_clock_alarm_bank_if #(
   parameter int NUM_ALARMS = 4
);
   localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

   logic             ALM_WE;
   logic [IDX_W-1:0] ALM_IDX;
   logic [15:0]      ALM_DATA;

   modport master (output ALM_WE, ALM_IDX, ALM_DATA);
   modport slave  (input  ALM_WE, ALM_IDX, ALM_DATA);
endinterface

// File: rtl/bcd_clock_alarm_bank.sv
// BCD HH:MM:SS timekeeper with 1 Hz prescaler, 12/24h view,
// field set, hourly pulse/chime chaser and a bank of alarms.
module bcd_clock_alarm_bank #(
   parameter int CLK_DIV    = 1,
   parameter int NUM_ALARMS = 4,
   parameter int ALARM_SECS = 60,
   parameter int LIGHT_W    = 6
) (
   input  logic                    Clk,
   input  logic                    RST,
   input  logic                    EN,
   input  logic                    Mode,
   input  logic [1:0]              SET,
   input  logic [7:0]              SETDATA,
   bcd_clock_alarm_bank_if.slave   alm,
   input  logic [NUM_ALARMS-1:0]   ALM_EN,
   input  logic [NUM_ALARMS-1:0]   ALM_ACK,
   output logic [7:0]              Hours,
   output logic [7:0]              Minutes,
   output logic [7:0]              Seconds,
   output logic                    PM,
   output logic                    Hour_pulse,
   output logic [LIGHT_W-1:0]      Light,
   output logic [NUM_ALARMS-1:0]   ALERT,
   output logic                    ALERT_ANY
);
   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   function automatic logic bcd_ok(logic [7:0] v, logic [7:0] max);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
   endfunction

   function automatic logic [7:0] bcd_inc(logic [7:0] v);
      return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0}
                              : {v[7:4], v[3:0] + 4'd1};
   endfunction

   logic [CNT_W-1:0]      cnt;
   logic [7:0]            hh, mm, ss;
   logic [7:0]            hh_n, mm_n, ss_n;
   logic [7:0]            h12;
   logic [15:0]           alarm [NUM_ALARMS];
   logic [7:0]            cd    [NUM_ALARMS];
   logic                  tick, step, set_ok, alm_ok, idx_ok;
   logic                  ss_wrap, mm_wrap, hr_roll;
   logic [NUM_ALARMS-1:0] match, wr;

   assign tick    = EN && (cnt == CNT_MAX);
   assign step    = tick && (SET == 2'b00);
   assign ss_wrap = (ss == 8'h59);
   assign mm_wrap = (mm == 8'h59);
   assign hr_roll = step && ss_wrap && mm_wrap;

   always_comb begin
      set_ok = 1'b0;
      unique case (1'b1)
         SET == 2'b01: set_ok = bcd_ok(SETDATA, 8'h23);
         SET[1]:       set_ok = bcd_ok(SETDATA, 8'h59);
         default:      set_ok = 1'b0;
      endcase
   end

   always_comb begin
      ss_n = ss_wrap ? 8'h00 : bcd_inc(ss);
      mm_n = mm;
      hh_n = hh;
      if (ss_wrap) mm_n = mm_wrap ? 8'h00 : bcd_inc(mm);
      if (ss_wrap && mm_wrap) hh_n = (hh == 8'h23) ? 8'h00 : bcd_inc(hh);
   end

   // a set cycle swallows the tick, so time only loads or steps
   always_ff @(posedge Clk or negedge RST) begin
      if (!RST) begin
         hh <= 8'h00;
         mm <= 8'h00;
         ss <= 8'h00;
      end else if (SET != 2'b00) begin
         if (set_ok) begin
            unique case (1'b1)
               SET == 2'b01: hh <= SETDATA;
               SET == 2'b10: mm <= SETDATA;
               default:      ss <= SETDATA;
            endcase
         end
      end else if (step) begin
         hh <= hh_n;
         mm <= mm_n;
         ss <= ss_n;
      end
   end

   always_ff @(posedge Clk or negedge RST) begin
      if (!RST) begin
         cnt <= '0;
      end else if (SET == 2'b11 && set_ok) begin
         cnt <= '0;
      end else if (EN) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge RST) begin
      if (!RST) begin
         Hour_pulse <= 1'b0;
         Light      <= '0;
      end else begin
         Hour_pulse <= hr_roll;
         if (hr_roll) Light <= LIGHT_W'(1);
         else if (tick) Light <= {Light[LIGHT_W-2:0], 1'b0};
      end
   end

   assign idx_ok = {{(32-IDX_W){1'b0}}, alm.ALM_IDX} < 32'(NUM_ALARMS);
   assign alm_ok = alm.ALM_WE && idx_ok
                && bcd_ok(alm.ALM_DATA[15:8], 8'h23)
                && bcd_ok(alm.ALM_DATA[7:0], 8'h59);

   always_comb begin
      match = '0;
      wr    = '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         match[i] = step && ss_wrap && ALM_EN[i]
                 && ({hh_n, mm_n} == alarm[i]);
         wr[i]    = alm_ok && (alm.ALM_IDX == IDX_W'(i));
      end
   end

   // a fresh match outranks ack so the alarm re-arms
   always_ff @(posedge Clk or negedge RST) begin
      if (!RST) begin
         ALERT <= '0;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            alarm[i] <= 16'h0000;
            cd[i]    <= 8'h00;
         end
      end else begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (wr[i]) alarm[i] <= alm.ALM_DATA;
            if (match[i]) begin
               ALERT[i] <= 1'b1;
               cd[i]    <= 8'(ALARM_SECS);
            end else if (wr[i] || !ALM_EN[i] || ALM_ACK[i]) begin
               ALERT[i] <= 1'b0;
            end else if (ALERT[i] && tick) begin
               cd[i] <= cd[i] - 8'd1;
               if (cd[i] == 8'd1) ALERT[i] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      h12 = hh;
      if (hh == 8'h00) begin
         h12 = 8'h12;
      end else if (hh > 8'h12) begin
         if (hh[7:4] == 4'd1)     h12 = {4'd0, hh[3:0] - 4'd2};
         else if (hh[3:0] < 4'd2) h12 = {4'd0, hh[3:0] + 4'd8};
         else                     h12 = {4'd1, hh[3:0] - 4'd2};
      end
   end

   assign Hours     = Mode ? h12 : hh;
   assign Minutes   = mm;
   assign Seconds   = ss;
   assign PM        = (hh >= 8'h12);
   assign ALERT_ANY = |ALERT;
endmodule

// File: tb/tb_bcd_clock_alarm_bank.sv
// Bench for bcd_clock_alarm_bank: directed scenarios plus random
// traffic, checked against a seconds-of-day reference model.
module tb_bcd_clock_alarm_bank;
   localparam int CLK_DIV = 4;
   localparam int NA      = 4;
   localparam int ASECS   = 3;
   localparam int LW      = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          mode = 1'b0;
   logic [1:0]    set = 2'b00;
   logic [7:0]    setdata = 8'h00;
   logic [NA-1:0] alm_en = '0;
   logic [NA-1:0] alm_ack = '0;
   logic [7:0]    hours, minutes, seconds;
   logic          pm, hour_pulse, alert_any;
   logic [LW-1:0] light;
   logic [NA-1:0] alert;

   bcd_clock_alarm_bank_if #(.NUM_ALARMS(NA)) alm();

   bcd_clock_alarm_bank #(
      .CLK_DIV(CLK_DIV), .NUM_ALARMS(NA),
      .ALARM_SECS(ASECS), .LIGHT_W(LW)
   ) dut (
      .Clk(clk), .RST(rst_n), .EN(en), .Mode(mode),
      .SET(set), .SETDATA(setdata), .alm(alm.slave),
      .ALM_EN(alm_en), .ALM_ACK(alm_ack),
      .Hours(hours), .Minutes(minutes), .Seconds(seconds),
      .PM(pm), .Hour_pulse(hour_pulse), .Light(light),
      .ALERT(alert), .ALERT_ANY(alert_any)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference model state: time as seconds of day, alarms as minutes of day
   int m_t, m_pc, m_light;
   int m_alm [NA];
   int m_cd  [NA];
   bit m_al  [NA];
   bit m_hp;

   function automatic logic [7:0] to_bcd(int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   function automatic bit dec(logic [7:0] d, int max, output int v);
      v = int'(d[7:4]) * 10 + int'(d[3:0]);
      return (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9) && (v <= max);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_t = 0; m_pc = 0; m_light = 0; m_hp = 0;
      for (int i = 0; i < NA; i++) begin
         m_alm[i] = 0; m_cd[i] = 0; m_al[i] = 0;
      end
   endtask

   task automatic m_step();
      bit tk, stp, sv, wv;
      int nt, v, hv, mv;
      bit mt [NA];
      tk = en && (m_pc == CLK_DIV - 1);
      stp = tk && (set == 2'b00);
      nt = stp ? (m_t + 1) % 86400 : m_t;
      m_hp = stp && (m_t % 3600 == 3599);
      for (int i = 0; i < NA; i++)
         mt[i] = stp && (nt % 60 == 0) && alm_en[i] && (nt / 60 == m_alm[i]);
      wv = alm.ALM_WE && dec(alm.ALM_DATA[15:8], 23, hv)
        && dec(alm.ALM_DATA[7:0], 59, mv);
      for (int i = 0; i < NA; i++) begin
         if (mt[i]) begin
            m_al[i] = 1; m_cd[i] = ASECS;
         end else if (wv && int'(alm.ALM_IDX) == i) begin
            m_al[i] = 0;
         end else if (!alm_en[i] || alm_ack[i]) begin
            m_al[i] = 0;
         end else if (m_al[i] && tk) begin
            m_cd[i]--;
            if (m_cd[i] == 0) m_al[i] = 0;
         end
      end
      if (wv) m_alm[alm.ALM_IDX] = hv * 60 + mv;
      if (m_hp) m_light = 1;
      else if (tk) m_light = (m_light * 2) % (1 << LW);
      sv = 0;
      case (set)
         2'b01: if (dec(setdata, 23, v)) m_t = v * 3600 + m_t % 3600;
         2'b10: if (dec(setdata, 59, v)) m_t = (m_t / 3600) * 3600 + v * 60 + m_t % 60;
         2'b11: if (dec(setdata, 59, v)) begin m_t = m_t - m_t % 60 + v; sv = 1; end
         default: m_t = nt;
      endcase
      if (sv) m_pc = 0;
      else if (en) m_pc = (m_pc + 1) % CLK_DIV;
   endtask

   task automatic check_all();
      int h, h12;
      logic [NA-1:0] ea;
      h = m_t / 3600;
      h12 = (h == 0) ? 12 : (h > 12 ? h - 12 : h);
      ea = '0;
      for (int i = 0; i < NA; i++) ea[i] = m_al[i];
      chk("hours", 32'(hours), 32'(mode ? to_bcd(h12) : to_bcd(h)));
      chk("minutes", 32'(minutes), 32'(to_bcd((m_t / 60) % 60)));
      chk("seconds", 32'(seconds), 32'(to_bcd(m_t % 60)));
      chk("pm", 32'(pm), 32'(h >= 12));
      chk("hour_pulse", 32'(hour_pulse), 32'(m_hp));
      chk("light", 32'(light), 32'(m_light));
      chk("alert", 32'(alert), 32'(ea));
      chk("alert_any", 32'(alert_any), 32'(ea != 0));
   endtask

   task automatic cyc();
      @(posedge clk);
      m_step();
      #1;
      check_all();
   endtask

   task automatic set_field(logic [1:0] f, logic [7:0] d);
      set = f; setdata = d;
      cyc();
      set = 2'b00;
   endtask

   task automatic wr_alarm(logic [1:0] idx, logic [15:0] d);
      alm.ALM_WE = 1'b1; alm.ALM_IDX = idx; alm.ALM_DATA = d;
      cyc();
      alm.ALM_WE = 1'b0;
   endtask

   initial begin
      bit seen;
      logic [23:0] snap;
      logic [7:0] hin [4];
      logic [7:0] hout [4];
      logic [3:0] pout;
      int mn;
      hin  = '{8'h00, 8'h12, 8'h13, 8'h23};
      hout = '{8'h12, 8'h12, 8'h01, 8'h11};
      pout = 4'b1110;
      alm.ALM_WE = 1'b0; alm.ALM_IDX = '0; alm.ALM_DATA = '0;
      m_reset();

      // reset state in both display modes
      mode = 1'b1;
      #12;
      chk("rst_hours12", 32'(hours), 32'h12);
      mode = 1'b0;
      #1;
      chk("rst_hours24", 32'(hours), 32'h00);
      chk("rst_time", 32'({minutes, seconds}), 32'h0);
      chk("rst_flags", 32'({pm, hour_pulse, light, alert}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      en = 1'b1;

      // rollover 23:59:58 -> 00:00:00 with pulse and chaser
      set_field(2'b01, 8'h23);
      set_field(2'b10, 8'h59);
      set_field(2'b11, 8'h58);
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         cyc();
         if (m_hp) begin
            seen = 1;
            chk("roll_time", 32'({hours, minutes, seconds}), 32'h0);
            chk("roll_pulse", 32'(hour_pulse), 32'h1);
            chk("roll_light", 32'(light), 32'h1);
         end
      end
      chk("roll_seen", 32'(seen), 32'h1);
      cyc();
      chk("pulse_width", 32'(hour_pulse), 32'h0);
      repeat (6 * CLK_DIV - 1) cyc();
      chk("light_clear", 32'(light), 32'h0);

      // set priority over tick, invalid data ignored
      set_field(2'b11, 8'h10);
      repeat (3) cyc();
      set_field(2'b11, 8'h30);
      chk("set_prio", 32'(seconds), 32'h30);
      repeat (3) cyc();
      chk("presc_clr", 32'(seconds), 32'h30);
      cyc();
      chk("presc_tick", 32'(seconds), 32'h31);
      snap = {hours, minutes, seconds};
      set_field(2'b01, 8'h24);
      chk("set_bad_h", 32'(hours), 32'(snap[23:16]));
      set_field(2'b10, 8'h5A);
      chk("set_bad_m", 32'(minutes), 32'(snap[15:8]));

      // 12h mapping
      en = 1'b0;
      mode = 1'b1;
      set_field(2'b10, 8'h00);
      for (int k = 0; k < 4; k++) begin
         set_field(2'b01, hin[k]);
         chk("h12_map", 32'(hours), 32'(hout[k]));
         chk("h12_pm", 32'(pm), 32'(pout[k]));
      end
      mode = 1'b0;

      // two channels firing together, ack and auto-clear
      wr_alarm(2'd0, 16'h0655);
      wr_alarm(2'd2, 16'h0655);
      alm_en = 4'b0101;
      set_field(2'b01, 8'h06);
      set_field(2'b10, 8'h54);
      set_field(2'b11, 8'h59);
      en = 1'b1;
      repeat (4) cyc();
      chk("alm_fire", 32'(alert), 32'h5);
      alm_ack = 4'b0001;
      cyc();
      alm_ack = 4'b0000;
      chk("alm_ack", 32'(alert), 32'h4);
      repeat (10) cyc();
      chk("alm_hold", 32'(alert), 32'h4);
      cyc();
      chk("alm_auto", 32'(alert), 32'h0);

      // match on the hourly rollover beats a same-cycle ack
      en = 1'b0;
      alm_en = 4'b0010;
      wr_alarm(2'd1, 16'h0700);
      set_field(2'b01, 8'h06);
      set_field(2'b10, 8'h59);
      set_field(2'b11, 8'h59);
      en = 1'b1;
      repeat (3) cyc();
      alm_ack = 4'b0010;
      cyc();
      alm_ack = 4'b0000;
      chk("hp_alm", 32'({alert[1], hour_pulse}), 32'h3);
      chk("hp_time7", 32'({hours, minutes, seconds}), 32'h070000);

      // EN low freezes time, then async reset mid-count
      en = 1'b0;
      snap = {hours, minutes, seconds};
      repeat (20) cyc();
      chk("en_freeze", 32'({hours, minutes, seconds}), 32'(snap));
      en = 1'b1;
      repeat (6) cyc();
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_time", 32'({hours, minutes, seconds}), 32'h0);
      chk("async_flags", 32'({pm, hour_pulse, light, alert, alert_any}), 32'h0);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // random traffic against the model
      for (int k = 0; k < 800; k++) begin
         en = ($urandom_range(9) != 0);
         mode = 1'($urandom_range(1));
         set = 2'b00;
         if ($urandom_range(15) == 0) begin
            set = 2'($urandom_range(3, 1));
            setdata = $urandom_range(1) ? to_bcd(int'($urandom_range(59)))
                                        : 8'($urandom);
         end
         alm.ALM_WE = ($urandom_range(11) == 0);
         alm.ALM_IDX = 2'($urandom_range(3));
         mn = (m_t / 60 + int'($urandom_range(1))) % 1440;
         alm.ALM_DATA = ($urandom_range(7) == 0) ? 16'($urandom)
                      : {to_bcd(mn / 60), to_bcd(mn % 60)};
         if ($urandom_range(31) == 0) alm_en = 4'($urandom);
         alm_ack = 4'($urandom) & 4'($urandom) & 4'($urandom);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
